// File: rtl/embalador_caixas_if.sv
// Packing-stage signal bundle between the bottling line controller and the
// box packer.
//   master : line/sensor side; drives garrafa_in, caixa_presente, fecha_ok,
//            esteira_livre and reconhece; observes actuators and status.
//   slave  : packer side; drives pare_linha, fecha_caixa, ejeta_caixa,
//            alarme, lote_completo, garrafas, caixas_dezenas,
//            caixas_unidades and estado.
interface embalador_caixas_if;
  logic       garrafa_in;
  logic       caixa_presente;
  logic       fecha_ok;
  logic       esteira_livre;
  logic       reconhece;
  logic       pare_linha;
  logic       fecha_caixa;
  logic       ejeta_caixa;
  logic       alarme;
  logic       lote_completo;
  logic [3:0] garrafas;
  logic [3:0] caixas_dezenas;
  logic [3:0] caixas_unidades;
  logic [2:0] estado;

  modport master (
    output garrafa_in, caixa_presente, fecha_ok, esteira_livre, reconhece,
    input  pare_linha, fecha_caixa, ejeta_caixa, alarme, lote_completo,
           garrafas, caixas_dezenas, caixas_unidades, estado
  );

  modport slave (
    input  garrafa_in, caixa_presente, fecha_ok, esteira_livre, reconhece,
    output pare_linha, fecha_caixa, ejeta_caixa, alarme, lote_completo,
           garrafas, caixas_dezenas, caixas_unidades, estado
  );
endinterface

// File: rtl/embalador_caixas.sv
// Box packer downstream of the bottle sealer. Counts sealed bottles into
// boxes, drives the box sealer and ejector, keeps a BCD count of boxes on
// the current pallet and stops the line / raises an alarm on packing faults.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : embalador_caixas_if.slave (sensors in, actuators/status out)
// Every output comes straight from a flop; actuator flops are loaded from
// the next-state decode so they line up with the state they belong to.
module embalador_caixas #(
  parameter int GARRAFAS_POR_CAIXA = 12,
  parameter int CAIXAS_POR_LOTE    = 24,
  parameter int T_FECHA            = 50000
) (
  input  logic               clock,
  input  logic               reset,
  embalador_caixas_if.slave  bus
);

  localparam int         TW    = (T_FECHA > 1) ? $clog2(T_FECHA) : 1;
  localparam logic [3:0] G_MAX = 4'(GARRAFAS_POR_CAIXA);
  localparam logic [6:0] LOTE  = 7'(CAIXAS_POR_LOTE);

  typedef enum logic [2:0] {
    ESPERA_CAIXA = 3'd0,
    ENCHENDO     = 3'd1,
    FECHANDO     = 3'd2,
    EJETANDO     = 3'd3,
    ALARME       = 3'd4
  } estado_t;

  estado_t         state, state_nxt;
  logic            garrafa_d, bot;
  logic [3:0]      garrafas_q, garrafas_nxt;
  logic [3:0]      dez_q, dez_nxt, uni_q, uni_nxt;
  logic [3:0]      inc_dez, inc_uni;
  logic            inc_wrap;
  logic            lote_q, lote_nxt;
  logic [TW-1:0]   timer_q, timer_nxt;
  logic            pare_q, pare_nxt;
  logic            fecha_q, fecha_nxt;
  logic            ejeta_q, ejeta_nxt;
  logic            alarme_q, alarme_nxt;

  // One count per rising edge of the sealed-bottle level.
  assign bot = bus.garrafa_in & ~garrafa_d;

  // BCD +1 of the pallet count, and whether that value closes the pallet.
  always_comb begin
    if (uni_q == 4'd9) begin
      inc_uni = 4'd0;
      inc_dez = dez_q + 4'd1;
    end else begin
      inc_uni = uni_q + 4'd1;
      inc_dez = dez_q;
    end
    inc_wrap = ((7'(inc_dez) * 7'd10) + 7'(inc_uni)) == LOTE;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ESPERA_CAIXA;
    else       state <= state_nxt;
  end

  // Next state plus the counters that move with it.
  always_comb begin
    state_nxt    = state;
    garrafas_nxt = garrafas_q;
    dez_nxt      = dez_q;
    uni_nxt      = uni_q;
    lote_nxt     = 1'b0;
    timer_nxt    = '0;
    case (state)
      ESPERA_CAIXA: begin
        // A bottle with no box under the filler is a fault even if a box
        // arrives in the same cycle.
        if (bot)                     state_nxt = ALARME;
        else if (bus.caixa_presente) state_nxt = ENCHENDO;
      end
      ENCHENDO: begin
        // Box pulled away: scrap path wins, the coincident bottle is lost.
        if (!bus.caixa_presente) state_nxt = ALARME;
        else if (bot) begin
          garrafas_nxt = garrafas_q + 4'd1;
          if (garrafas_q == G_MAX - 4'd1) state_nxt = FECHANDO;
        end
      end
      FECHANDO: begin
        if (bot)                               state_nxt = ALARME;
        else if (bus.fecha_ok)                 state_nxt = EJETANDO;
        else if (timer_q == TW'(T_FECHA - 1))  state_nxt = ALARME;
        else                                   timer_nxt = timer_q + TW'(1);
      end
      EJETANDO: begin
        if (bot) state_nxt = ALARME;
        else if (!bus.caixa_presente) begin
          state_nxt    = ESPERA_CAIXA;
          garrafas_nxt = 4'd0;
          if (inc_wrap) begin
            dez_nxt  = 4'd0;
            uni_nxt  = 4'd0;
            lote_nxt = 1'b1;
          end else begin
            dez_nxt = inc_dez;
            uni_nxt = inc_uni;
          end
        end
      end
      ALARME: begin
        // Operator must acknowledge with the faulty box already removed.
        if (bus.reconhece && !bus.caixa_presente) begin
          state_nxt    = ESPERA_CAIXA;
          garrafas_nxt = 4'd0;
        end
      end
      default: state_nxt = ESPERA_CAIXA;
    endcase
  end

  // Output decode from the upcoming state, so the flops below present the
  // actuator levels together with the state they belong to.
  always_comb begin
    pare_nxt   = (state_nxt != ENCHENDO);
    fecha_nxt  = (state_nxt == FECHANDO);
    alarme_nxt = (state_nxt == ALARME);
    ejeta_nxt  = (state_nxt == EJETANDO) && bus.esteira_livre;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      garrafa_d  <= 1'b0;
      garrafas_q <= 4'd0;
      dez_q      <= 4'd0;
      uni_q      <= 4'd0;
      lote_q     <= 1'b0;
      timer_q    <= '0;
      pare_q     <= 1'b1;
      fecha_q    <= 1'b0;
      ejeta_q    <= 1'b0;
      alarme_q   <= 1'b0;
    end else begin
      garrafa_d  <= bus.garrafa_in;
      garrafas_q <= garrafas_nxt;
      dez_q      <= dez_nxt;
      uni_q      <= uni_nxt;
      lote_q     <= lote_nxt;
      timer_q    <= timer_nxt;
      pare_q     <= pare_nxt;
      fecha_q    <= fecha_nxt;
      ejeta_q    <= ejeta_nxt;
      alarme_q   <= alarme_nxt;
    end
  end

  assign bus.pare_linha      = pare_q;
  assign bus.fecha_caixa     = fecha_q;
  assign bus.ejeta_caixa     = ejeta_q;
  assign bus.alarme          = alarme_q;
  assign bus.lote_completo   = lote_q;
  assign bus.garrafas        = garrafas_q;
  assign bus.caixas_dezenas  = dez_q;
  assign bus.caixas_unidades = uni_q;
  assign bus.estado          = state;

endmodule

// File: tb/tb_embalador_caixas.sv
// Self-checking bench for embalador_caixas: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model of
// the packing rules (box fill count, pallet count as a plain integer,
// cycles spent waiting for the sealer).
module tb_embalador_caixas;
  localparam int G = 12;
  localparam int L = 3;
  localparam int T = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  embalador_caixas_if bus();

  embalador_caixas #(
    .GARRAFAS_POR_CAIXA(G),
    .CAIXAS_POR_LOTE(L),
    .T_FECHA(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 wait box, 1 filling, 2 sealing, 3 ejecting, 4 alarm.
  int m_st, m_garr, m_boxes, m_seal;
  bit m_gd, m_lote, m_ejeta;

  task automatic model_reset();
    m_st = 0; m_garr = 0; m_boxes = 0; m_seal = 0;
    m_gd = 1'b0; m_lote = 1'b0; m_ejeta = 1'b0;
  endtask

  // {pare, fecha, ejeta, alarme, lote, garrafas, dezenas, unidades, estado}
  function automatic logic [19:0] exp_vec();
    return {(m_st != 1), (m_st == 2), m_ejeta, (m_st == 4), m_lote,
            4'(m_garr), 4'(m_boxes / 10), 4'(m_boxes % 10), 3'(m_st)};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {bus.pare_linha, bus.fecha_caixa, bus.ejeta_caixa, bus.alarme,
            bus.lote_completo, bus.garrafas, bus.caixas_dezenas,
            bus.caixas_unidades, bus.estado};
  endfunction

  // Advance the model with the inputs now applied, then one clock.
  task automatic tick();
    bit bot;
    int ns;
    bot    = bus.garrafa_in && !m_gd;
    ns     = m_st;
    m_lote = 1'b0;
    case (m_st)
      0: if (bot) ns = 4; else if (bus.caixa_presente) ns = 1;
      1: begin
        if (!bus.caixa_presente) ns = 4;
        else if (bot) begin
          m_garr++;
          if (m_garr == G) ns = 2;
        end
      end
      2: begin
        m_seal++;  // cycles spent sealing, this one included
        if (bot) ns = 4;
        else if (bus.fecha_ok) ns = 3;
        else if (m_seal == T) ns = 4;
      end
      3: begin
        if (bot) ns = 4;
        else if (!bus.caixa_presente) begin
          m_garr = 0;
          m_boxes++;
          if (m_boxes == L) begin m_boxes = 0; m_lote = 1'b1; end
          ns = 0;
        end
      end
      default: if (bus.reconhece && !bus.caixa_presente) begin ns = 0; m_garr = 0; end
    endcase
    if (ns == 2 && m_st != 2) m_seal = 0;
    m_ejeta = (ns == 3) && bus.esteira_livre;
    m_gd    = bus.garrafa_in;
    m_st    = ns;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    bus.garrafa_in = 1'b1; tick();
    bus.garrafa_in = 1'b0; tick();
  endtask

  task automatic full_box();
    bus.caixa_presente = 1'b1; tick();
    repeat (G) pulse();
    bus.fecha_ok = 1'b1; tick();
    bus.fecha_ok = 1'b0;
    bus.caixa_presente = 1'b0; tick();
  endtask

  task automatic zero_inputs();
    bus.garrafa_in = 1'b0; bus.caixa_presente = 1'b0; bus.fecha_ok = 1'b0;
    bus.esteira_livre = 1'b0; bus.reconhece = 1'b0;
  endtask

  task automatic test_reset();
    zero_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.pare_linha !== 1'b1) begin errors++; $display("FAIL reset_pare got %b want 1", bus.pare_linha); end
    checks++; if (obs_vec() !== 20'h80000) begin errors++; $display("FAIL reset_outputs got %h want %h", obs_vec(), 20'h80000); end
    @(posedge clock); #1;
    checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_held got %h want %h", obs_vec(), exp_vec()); end
    reset = 1'b0;
    tick();
    checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_normal_box();
    bus.caixa_presente = 1'b1; tick();
    checks++; if (bus.estado !== 3'd1 || bus.pare_linha !== 1'b0) begin errors++; $display("FAIL normal_enter got estado %0d pare %b want 1 0", bus.estado, bus.pare_linha); end
    for (int i = 1; i <= G; i++) begin
      bus.garrafa_in = 1'b1; tick();
      checks++; if (bus.garrafas !== 4'(i)) begin errors++; $display("FAIL normal_count got %0d want %0d", bus.garrafas, i); end
      bus.garrafa_in = 1'b0; tick();
    end
    checks++; if (bus.estado !== 3'd2 || bus.fecha_caixa !== 1'b1) begin errors++; $display("FAIL normal_sealing got estado %0d fecha %b want 2 1", bus.estado, bus.fecha_caixa); end
    bus.esteira_livre = 1'b1; bus.fecha_ok = 1'b1; tick();
    checks++; if (bus.estado !== 3'd3 || bus.fecha_caixa !== 1'b0 || bus.ejeta_caixa !== 1'b1) begin
      errors++; $display("FAIL normal_eject got estado %0d fecha %b ejeta %b want 3 0 1", bus.estado, bus.fecha_caixa, bus.ejeta_caixa); end
    bus.fecha_ok = 1'b0; bus.esteira_livre = 1'b0;
    bus.caixa_presente = 1'b0; tick();
    checks++; if (bus.garrafas !== 4'd0 || bus.caixas_dezenas !== 4'd0 || bus.caixas_unidades !== 4'd1 || bus.estado !== 3'd0) begin
      errors++; $display("FAIL normal_done got g %0d box %0d%0d estado %0d want 0 01 0", bus.garrafas, bus.caixas_dezenas, bus.caixas_unidades, bus.estado); end
    checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL normal_model got %h want %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_pallet_wrap();
    full_box();
    checks++; if (bus.caixas_unidades !== 4'd2 || bus.lote_completo !== 1'b0) begin errors++; $display("FAIL wrap_two got %0d lote %b want 2 0", bus.caixas_unidades, bus.lote_completo); end
    full_box();
    checks++; if ({bus.caixas_dezenas, bus.caixas_unidades} !== 8'h00 || bus.lote_completo !== 1'b1) begin
      errors++; $display("FAIL wrap_zero got %0d%0d lote %b want 00 1", bus.caixas_dezenas, bus.caixas_unidades, bus.lote_completo); end
    tick();
    checks++; if (bus.lote_completo !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", bus.lote_completo); end
    full_box();
    checks++; if ({bus.caixas_dezenas, bus.caixas_unidades} !== 8'h01) begin errors++; $display("FAIL wrap_next got %0d%0d want 01", bus.caixas_dezenas, bus.caixas_unidades); end
  endtask

  task automatic test_no_box_fault();
    bus.caixa_presente = 1'b0; bus.garrafa_in = 1'b1; tick();
    checks++; if (bus.alarme !== 1'b1 || bus.estado !== 3'd4) begin errors++; $display("FAIL nobox_alarm got alarme %b estado %0d want 1 4", bus.alarme, bus.estado); end
    bus.garrafa_in = 1'b0; tick();
    pulse();
    checks++; if (bus.garrafas !== 4'd0 || bus.estado !== 3'd4) begin errors++; $display("FAIL nobox_ignore got g %0d estado %0d want 0 4", bus.garrafas, bus.estado); end
    bus.reconhece = 1'b1; bus.caixa_presente = 1'b1; tick();
    checks++; if (bus.estado !== 3'd4) begin errors++; $display("FAIL nobox_ack_box got %0d want 4", bus.estado); end
    bus.caixa_presente = 1'b0; tick();
    bus.reconhece = 1'b0;
    checks++; if (bus.estado !== 3'd0 || bus.alarme !== 1'b0 || bus.caixas_unidades !== 4'd1) begin
      errors++; $display("FAIL nobox_exit got estado %0d alarme %b box %0d want 0 0 1", bus.estado, bus.alarme, bus.caixas_unidades); end
  endtask

  task automatic test_timeout();
    bus.caixa_presente = 1'b1; tick();
    repeat (G - 1) pulse();
    bus.garrafa_in = 1'b1; tick();
    bus.garrafa_in = 1'b0;
    for (int k = 1; k < T; k++) begin
      tick();
      checks++; if (bus.estado !== 3'd2 || bus.alarme !== 1'b0) begin errors++; $display("FAIL timeout_early cycle %0d got estado %0d want 2", k, bus.estado); end
    end
    tick();
    checks++; if (bus.alarme !== 1'b1 || bus.fecha_caixa !== 1'b0 || bus.estado !== 3'd4) begin
      errors++; $display("FAIL timeout_alarm got alarme %b fecha %b estado %0d want 1 0 4", bus.alarme, bus.fecha_caixa, bus.estado); end
    bus.caixa_presente = 1'b0; bus.reconhece = 1'b1; tick();
    bus.reconhece = 1'b0;
    checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL timeout_clear got %h want %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_held_and_simultaneous();
    bus.caixa_presente = 1'b1; tick();
    bus.garrafa_in = 1'b1;
    repeat (10) tick();
    checks++; if (bus.garrafas !== 4'd1) begin errors++; $display("FAIL held_once got %0d want 1", bus.garrafas); end
    bus.garrafa_in = 1'b0; tick();
    repeat (4) pulse();
    checks++; if (bus.garrafas !== 4'd5) begin errors++; $display("FAIL held_five got %0d want 5", bus.garrafas); end
    bus.garrafa_in = 1'b1; bus.caixa_presente = 1'b0; tick();
    checks++; if (bus.estado !== 3'd4 || bus.garrafas !== 4'd5) begin errors++; $display("FAIL simul_alarm got estado %0d g %0d want 4 5", bus.estado, bus.garrafas); end
    bus.garrafa_in = 1'b0; bus.reconhece = 1'b1; tick();
    bus.reconhece = 1'b0;
    checks++; if (bus.garrafas !== 4'd0 || bus.estado !== 3'd0) begin errors++; $display("FAIL simul_scrap got g %0d estado %0d want 0 0", bus.garrafas, bus.estado); end
  endtask

  task automatic test_random();
    int cp_pct;
    for (int n = 0; n < 3000; n++) begin
      cp_pct = (m_st >= 3) ? 50 : 97;
      bus.garrafa_in     = ($urandom_range(99) < 50);
      bus.caixa_presente = ($urandom_range(99) < cp_pct);
      bus.fecha_ok       = ($urandom_range(99) < 20);
      bus.esteira_livre  = ($urandom_range(99) < 50);
      bus.reconhece      = ($urandom_range(99) < 30);
      tick();
      checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random cycle %0d got %h want %h", n, obs_vec(), exp_vec()); end
    end
    zero_inputs();
    reset = 1'b1; #1; reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_reset_mid_fill();
    bus.caixa_presente = 1'b1; tick();
    repeat (7) pulse();
    checks++; if (bus.garrafas !== 4'd7 || bus.estado !== 3'd1) begin errors++; $display("FAIL midfill_seven got g %0d estado %0d want 7 1", bus.garrafas, bus.estado); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (obs_vec() !== 20'h80000) begin errors++; $display("FAIL midfill_async got %h want %h", obs_vec(), 20'h80000); end
    reset = 1'b0;
    zero_inputs();
    tick();
    checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL midfill_after got %h want %h", obs_vec(), exp_vec()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal_box();
    test_pallet_wrap();
    test_no_box_fault();
    test_timeout();
    test_held_and_simultaneous();
    test_random();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/embalador_caixas.md
Name: embalador_caixas

Overview:
Downstream packing stage of the bottling line. It consumes the per-bottle "sealed" pulse (VE) from the main production FSM. Each box holds one dozen bottles. The block drives box sealing and ejection actuators, keeps a BCD count of boxes in the current pallet (lot), and raises a line-stop request and an alarm on packing faults. Its BCD outputs feed the existing multiplexed display.

Parameters:
GARRAFAS_POR_CAIXA, 12, bottles per box (legal range 1..15).
CAIXAS_POR_LOTE, 24, boxes per pallet (legal range 1..99). The BCD box counter wraps to 00 at this value.
T_FECHA, 50000, clock cycles allowed for fecha_ok after fecha_caixa rises. If exceeded, the block goes to ALARME.

Ports:
clock  in  1  system clock. All state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
garrafa_in  in  1  bottle-sealed level (VE). Synchronous to clock. Counted once per rising edge.
caixa_presente  in  1  box-in-position sensor (1 = box present).
fecha_ok  in  1  box-sealer done acknowledge.
esteira_livre  in  1  output conveyor ready to accept a box.
reconhece  in  1  operator alarm acknowledge.
pare_linha  out  1  request the upstream line to stop (gates MOTOR).
fecha_caixa  out  1  box-sealer actuator.
ejeta_caixa  out  1  box-ejector actuator.
alarme  out  1  packing fault indicator.
lote_completo  out  1  one-cycle pulse when a pallet completes.
garrafas  out  4  bottles in the current box, binary.
caixas_dezenas  out  4  boxes in the current pallet, BCD tens.
caixas_unidades  out  4  boxes in the current pallet, BCD units.
estado  out  3  state code for debug LEDs.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = ESPERA_CAIXA (code 0).
  - All counters = 0; edge register = 0; timer = 0.
  - All outputs 0, except pare_linha = 1.
- Edge detect: bot = garrafa_in & ~garrafa_d. garrafa_d is a registered copy of garrafa_in. The count updates at the clock edge after bot is seen. A held-high garrafa_in counts once.
- States (estado codes: ESPERA_CAIXA=0, ENCHENDO=1, FECHANDO=2, EJETANDO=3, ALARME=4):
  - ESPERA_CAIXA:
    - pare_linha = 1.
    - caixa_presente = 1 -> ENCHENDO.
    - bot = 1 -> ALARME (takes priority).
  - ENCHENDO:
    - pare_linha = 0.
    - bot increments garrafas.
    - If bot occurs while garrafas = GARRAFAS_POR_CAIXA-1: garrafas becomes GARRAFAS_POR_CAIXA and the next state is FECHANDO.
    - caixa_presente = 0 -> ALARME. A simultaneous bot is not counted.
  - FECHANDO:
    - pare_linha = 1; fecha_caixa = 1.
    - Timer counts up from 0 on entry.
    - fecha_ok = 1 -> EJETANDO, and fecha_caixa drops on that edge.
    - Timer reaching T_FECHA-1 without fecha_ok -> ALARME.
    - bot -> ALARME.
    - fecha_ok and bot in the same cycle -> ALARME.
  - EJETANDO:
    - pare_linha = 1.
    - ejeta_caixa = esteira_livre (registered, one-cycle latency).
    - caixa_presente falling to 0:
      - garrafas cleared.
      - BCD box count incremented (units 9 -> 0 with tens carry).
      - Next state ESPERA_CAIXA.
    - If the incremented count equals CAIXAS_POR_LOTE: the count becomes 00 and lote_completo = 1 for exactly that one cycle.
    - bot -> ALARME.
  - ALARME:
    - alarme = 1, pare_linha = 1; fecha_caixa = ejeta_caixa = 0.
    - Exit only when reconhece = 1 and caixa_presente = 0 in the same cycle. Then go to ESPERA_CAIXA and clear garrafas (the box is scrapped).
    - The box count is preserved. Further bot pulses are ignored.
- All outputs are registered. BCD digits never exceed 9. garrafas never exceeds GARRAFAS_POR_CAIXA.

Test Plan:
- Normal box: reset, caixa_presente=1, then 12 bot pulses -> garrafas 1..12 and state FECHANDO. fecha_ok -> EJETANDO. caixa_presente=0 -> garrafas=0, caixas=01, state 0.
- Pallet wrap (CAIXAS_POR_LOTE=3): run 3 complete boxes -> caixas 01, 02, then 00 with lote_completo high for exactly 1 cycle. A 4th box -> 01.
- No-box fault: caixa_presente=0, one bot pulse -> alarme=1, estado=4. reconhece=1 with caixa_presente=1 -> stays in ALARME. reconhece=1 with caixa_presente=0 -> ESPERA_CAIXA, caixas unchanged.
- Sealer timeout (T_FECHA=8): fill box, hold fecha_ok=0 -> alarme=1 on the 8th cycle of FECHANDO, fecha_caixa=0.
- Held input / simultaneous events: garrafa_in held high for 10 cycles -> count +1 only. At garrafas=5, bot together with caixa_presente falling -> ALARME, garrafas stays 5.
- Reset mid-fill: assert reset at garrafas=7 in ENCHENDO, without waiting for a clock edge -> all outputs 0 and pare_linha=1 immediately.
